// File: rtl/change_dispenser.sv
// Vending payout stage: computes change and issues coins 10/5/1 greedily
// over a valid/ack handshake, with per-coin gap and jam detection.
module change_dispenser #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic [7:0] price,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    input  logic       coin_ack,
    output logic [7:0] change_left,
    output logic       busy,
    output logic       done,
    output logic       underpay,
    output logic       jam
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ?
                             TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE,
        JAM
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    left_q, left_d;
    logic          under_q, under_d;
    logic [8:0]    diff;
    logic [1:0]    denom_code;
    logic [7:0]    denom;

    assign diff = {1'b0, amount} - {1'b0, price};

    always_comb begin
        denom_code = 2'b00;
        denom      = 8'd1;
        if (left_q >= 8'd10) begin
            denom_code = 2'b10;
            denom      = 8'd10;
        end else if (left_q >= 8'd5) begin
            denom_code = 2'b01;
            denom      = 8'd5;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        under_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (diff[8]) begin
                        left_d  = 8'd0;
                        under_d = 1'b1;
                    end else if (diff[7:0] == 8'd0) begin
                        left_d  = 8'd0;
                        state_d = DONE;
                    end else begin
                        left_d  = diff[7:0];
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // an ack on the expiry cycle still completes the coin
                if (coin_ack) begin
                    left_d  = left_q - denom;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == TO_LAST) begin
                    state_d = JAM;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (left_q != 8'd0) ? ISSUE : DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            JAM: begin
                state_d = JAM;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            left_q  <= 8'd0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            under_q <= under_d;
        end
    end

    assign coin_valid  = (state_q == ISSUE);
    assign coin_type   = coin_valid ? denom_code : 2'b00;
    assign change_left = left_q;
    assign busy        = (state_q == ISSUE) || (state_q == GAP) ||
                         (state_q == DONE);
    assign done        = (state_q == DONE);
    assign underpay    = under_q;
    assign jam         = (state_q == JAM);

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy-change model.
module tb_change_dispenser;
    localparam int GAP = 3;
    localparam int TO  = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] amount;
    logic [7:0] price;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_ack;
    logic [7:0] change_left;
    logic       busy;
    logic       done;
    logic       underpay;
    logic       jam;

    int total = 0;
    int bad   = 0;

    change_dispenser #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .price      (price),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .coin_ack   (coin_ack),
        .change_left(change_left),
        .busy       (busy),
        .done       (done),
        .underpay   (underpay),
        .jam        (jam)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input int v);
        if (v == 10) return 2'b10;
        if (v == 5) return 2'b01;
        return 2'b00;
    endfunction

    task automatic run_payout(input int a, input int p, input int dmin,
                              input int dmax, input bit inject);
        int left;
        int coins[$];
        int n;
        int d;
        logic [1:0] ty;
        left = a - p;
        coins = {};
        for (int k = 0; k < left / 10; k++) coins.push_back(10);
        if ((left % 10) >= 5) coins.push_back(5);
        for (int k = 0; k < left % 5; k++) coins.push_back(1);

        amount = 8'(a);
        price  = 8'(p);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start a=%0d p=%0d: got %b want 1",
                     a, p, busy);
        end
        if (coins.size() == 0) begin
            total++;
            if (coin_valid !== 1'b0) begin
                bad++;
                $display("FAIL no_coin a=%0d p=%0d: got valid=%b want 0",
                         a, p, coin_valid);
            end
        end
        foreach (coins[i]) begin
            total++;
            if (coin_valid !== 1'b1) begin
                bad++;
                $display("FAIL coin_valid #%0d: got %b want 1", i, coin_valid);
            end
            ty = coin_type;
            total++;
            if (coin_type !== enc(coins[i])) begin
                bad++;
                $display("FAIL coin_type #%0d: got %b want %b",
                         i, coin_type, enc(coins[i]));
            end
            total++;
            if (change_left !== 8'(left)) begin
                bad++;
                $display("FAIL change_before #%0d: got %0d want %0d",
                         i, change_left, left);
            end
            d = int'($urandom_range(dmax, dmin));
            repeat (d) @(negedge clk);
            total++;
            if (coin_valid !== 1'b1 || coin_type !== ty) begin
                bad++;
                $display("FAIL coin_hold #%0d d=%0d: got v=%b t=%b want v=1 t=%b",
                         i, d, coin_valid, coin_type, ty);
            end
            coin_ack = 1'b1;
            @(negedge clk);
            coin_ack = 1'b0;
            left -= coins[i];
            total++;
            if (coin_valid !== 1'b0 || change_left !== 8'(left)) begin
                bad++;
                $display("FAIL after_ack #%0d: got v=%b left=%0d want v=0 left=%0d",
                         i, coin_valid, change_left, left);
            end
            n = 0;
            if (inject) begin
                start    = 1'b1;
                coin_ack = 1'b1;
                amount   = 8'd99;
                price    = 8'd0;
            end
            while (coin_valid !== 1'b1 && done !== 1'b1 && n < GAP + 4) begin
                @(negedge clk);
                start    = 1'b0;
                coin_ack = 1'b0;
                n++;
            end
            start    = 1'b0;
            coin_ack = 1'b0;
            total++;
            if (n != GAP) begin
                bad++;
                $display("FAIL gap #%0d: got %0d cycles want %0d", i, n, GAP);
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse a=%0d p=%0d: got done=%b busy=%b want 1 1",
                     a, p, done, busy);
        end
        total++;
        if (underpay !== 1'b0 || jam !== 1'b0) begin
            bad++;
            $display("FAIL exclusive: got underpay=%b jam=%b want 0 0",
                     underpay, jam);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || coin_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_done: got done=%b busy=%b v=%b want 0 0 0",
                     done, busy, coin_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({coin_valid, coin_type, change_left, busy, done, underpay, jam}
            !== 15'd0) begin
            bad++;
            $display("FAIL reset_state: got v=%b t=%b left=%0d b=%b d=%b u=%b j=%b want all 0",
                     coin_valid, coin_type, change_left, busy, done,
                     underpay, jam);
        end
        reset = 1'b0;
    endtask

    task automatic test_underpay();
        amount = 8'd3;
        price  = 8'd6;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (underpay !== 1'b1 || busy !== 1'b0 || coin_valid !== 1'b0 ||
            change_left !== 8'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL underpay: got u=%b b=%b v=%b left=%0d d=%b want 1 0 0 0 0",
                     underpay, busy, coin_valid, change_left, done);
        end
        @(negedge clk);
        total++;
        if (underpay !== 1'b0 || coin_valid !== 1'b0) begin
            bad++;
            $display("FAIL underpay_pulse: got u=%b v=%b want 0 0",
                     underpay, coin_valid);
        end
        run_payout(12, 2, 0, 2, 1'b0);
    endtask

    task automatic test_jam();
        int n;
        amount = 8'd20;
        price  = 8'd1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (coin_valid !== 1'b1) begin
            bad++;
            $display("FAIL jam_first_valid: got %b want 1", coin_valid);
        end
        n = 0;
        while (jam !== 1'b1 && n < TO + 5) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                start  = 1'b1;
                amount = 8'd50;
                price  = 8'd0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (n != TO) begin
            bad++;
            $display("FAIL jam_latency: got %0d cycles want %0d", n, TO);
        end
        total++;
        if (change_left !== 8'd19 || coin_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || underpay !== 1'b0) begin
            bad++;
            $display("FAIL jam_outputs: got left=%0d v=%b b=%b d=%b u=%b want 19 0 0 0 0",
                     change_left, coin_valid, busy, done, underpay);
        end
        start  = 1'b1;
        amount = 8'd50;
        price  = 8'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (jam !== 1'b1 || coin_valid !== 1'b0 || change_left !== 8'd19) begin
            bad++;
            $display("FAIL jam_sticky: got j=%b v=%b left=%0d want 1 0 19",
                     jam, coin_valid, change_left);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (jam !== 1'b0 || change_left !== 8'd0) begin
            bad++;
            $display("FAIL jam_clear: got j=%b left=%0d want 0 0",
                     jam, change_left);
        end
    endtask

    task automatic test_reset_mid();
        amount = 8'd255;
        price  = 8'd0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) begin
            coin_ack = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        coin_ack = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        coin_ack = 1'b0;
        total++;
        if ({coin_valid, coin_type, change_left, busy, done, underpay, jam}
            !== 15'd0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b t=%b left=%0d b=%b d=%b u=%b j=%b want all 0",
                     coin_valid, coin_type, change_left, busy, done,
                     underpay, jam);
        end
        @(negedge clk);
        total++;
        if (coin_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got v=%b b=%b want 0 0",
                     coin_valid, busy);
        end
        run_payout(255, 0, 0, 6, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_payout(38, 3, 0, 3, 1'b1);
        run_payout(9, 0, 0, 2, 1'b0);
    endtask

    task automatic test_ack_at_expiry();
        run_payout(7, 0, TO - 1, TO - 1, 1'b0);
    endtask

    task automatic test_random();
        int a;
        int p;
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(255, 0));
            p = int'($urandom_range(a, 0));
            run_payout(a, p, 0, 4, 1'b0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        coin_ack = 1'b0;
        amount   = 8'd0;
        price    = 8'd0;
        test_reset();
        run_payout(27, 6, 1, 1, 1'b0);
        run_payout(6, 6, 0, 0, 1'b0);
        test_underpay();
        test_jam();
        test_reset_mid();
        test_back_to_back();
        test_ack_at_expiry();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
